issue_ctrl: RTL and testbench
=============================

// Module: issue_ctrl
// PURPOSE
//  Instruction queue plus dispatch sequencer in front of the combinational decoder `issue`.
//  It buffers fetched (ins, pc) pairs and presents the queue head to the decoder.
//  Each cycle it decides whether the decoded head may be dispatched to the ROB and to
//  either the RS or the LSB. It holds dispatch after a JALR until the target resolves,
//  and it empties the queue on a pipeline flush.
// PARAMETERS
//  IQ_AW     4   log2 of queue depth; depth IQ_DEPTH = 2**IQ_AW = 16 entries
// PORTS
//  clk_in       in   1   clock; all state changes on rising edge
//  rst_in       in   1   synchronous, active-high reset
//  rdy_in       in   1   global ready; when 0, all state frozen and all push outputs 0
//  clr_in       in   1   flush (mispredict or exception)
//  fet_vld      in   1   fetcher presents an instruction this cycle
//  fet_ins      in   32  instruction word
//  fet_pc       in   32  its PC
//  iq_full      out  1   registered; 1 when count == IQ_DEPTH; fetcher must not push
//  dec_flg      out  1   head valid; drives decoder ins_flg
//  dec_ins      out  32  head instruction; drives decoder ins
//  dec_pc       out  32  head PC; drives decoder pc
//  dec_optype   in   4   decoder optype (def.v codes)
//  dec_opcode   in   4   decoder opcode (def.v codes)
//  rob_full_in  in   1   ROB cannot accept this cycle
//  rs_full_in   in   1   RS cannot accept this cycle
//  lsb_full_in  in   1   LSB cannot accept this cycle
//  jalr_done_in in   1   JALR target resolved; fetch restarts at the correct PC
//  rob_push     out  1   dispatch strobe to ROB
//  rs_push      out  1   dispatch strobe to RS
//  lsb_push     out  1   dispatch strobe to LSB
// BEHAVIOUR
//  Storage: circular buffer with head, tail and count[IQ_AW:0]. Pointers wrap modulo IQ_DEPTH.
//  Reset: head = tail = count = 0 and state = RUN. At reset, iq_full = 0, dec_flg = 0,
//    and all push strobes = 0. Storage contents are don't-care.
//  Head outputs are combinational from the buffer: dec_flg = (count != 0).
//    dec_ins and dec_pc are don't-care when dec_flg = 0.
//  Latency: a push at edge t into an empty queue gives dec_flg = 1 in the cycle after edge t.
//    There is no bypass from fet_* to dec_*.
//  Routing: tgt_lsb = (dec_optype == `LAD or `STR); otherwise the target is the RS.
//  fire = rdy_in & ~clr_in & dec_flg & (state == RUN) & ~rob_full_in
//         & (tgt_lsb ? ~lsb_full_in : ~rs_full_in).
//  Strobes (combinational):
//    rob_push = fire
//    lsb_push = fire & tgt_lsb
//    rs_push  = fire & ~tgt_lsb
//  Pop: when fire is 1, head increments and the entry is consumed at that edge.
//  Push: accepted when fet_vld & rdy_in & ~clr_in & (count < IQ_DEPTH).
//    The entry is written at tail and tail increments.
//    A push attempted while full is dropped, even if a pop happens in the same cycle.
//  Simultaneous push and pop: count is unchanged; head and tail both advance.
//    With count == 1, the new entry becomes the head in the next cycle.
//  FSM:
//    RUN -> WAIT_JALR when fire & dec_optype == `JUM & dec_opcode == `JALR.
//    WAIT_JALR: fire is forced to 0; fetch pushes are still accepted.
//    WAIT_JALR -> RUN on jalr_done_in or clr_in.
//    jalr_done_in is ignored while in RUN.
//  Flush: clr_in = 1 (with rdy_in = 1) at an edge sets head = tail = count = 0 and state = RUN.
//    There are no strobes in that cycle, and the fet_* input of that cycle is discarded.
//    Flush has priority over push, pop and jalr_done_in.
//  rdy_in = 0: no pointer, count or state update; strobes are 0; clr_in is also ignored.
//  Reset mid-operation: same effect as a flush, plus all registered outputs are cleared.
// TESTING
//  1. Reset, then push 3 ADD (0x002081b3, pc 0/4/8) with ROB/RS not full ->
//     rs_push and rob_push high for 3 consecutive cycles starting 1 cycle after the first push;
//     dec_pc shows 0, 4, 8.
//  2. Push 16 entries with rob_full_in = 1 -> iq_full = 1 after the 16th.
//     Then a 17th push with rob_full_in = 0 -> it is dropped; exactly 16 dispatches follow.
//  3. Head LW (0x0000a103) with lsb_full_in = 1 -> no strobes.
//     Drop lsb_full_in -> lsb_push = 1 and rob_push = 1 with rs_push = 0.
//  4. Head JALR (0x000080e7) followed by an ADD -> JALR dispatched; ADD held for 5 cycles.
//     Pulse jalr_done_in -> ADD dispatches in the next cycle.
//  5. Queue holding 8 entries, then assert clr_in together with fet_vld ->
//     next cycle dec_flg = 0 and count = 0; no strobe during the flush cycle.
//  6. rdy_in = 0 for 3 cycles with a valid head and free targets ->
//     no strobes and no pointer change; dispatch resumes when rdy_in returns to 1.

Source files
------------

// File: rtl/issue_ctrl.sv
// issue_ctrl: instruction queue and dispatch sequencer in front of the combinational decoder.
//
// Fetched (ins, pc) pairs are buffered in a circular queue of 2**IQ_AW entries. The head entry
// is presented to the decoder. Each cycle the decoded head is dispatched to the ROB and to the
// RS or LSB if all targets can accept it. Dispatch is held after a JALR until its target
// resolves. A flush empties the queue.
//
// Ports
//   clk_in        clock, rising edge
//   rst_in        synchronous active-high reset
//   rdy_in        global ready; 0 freezes all state and suppresses strobes
//   clr_in        pipeline flush
//   fet_vld/ins/pc   fetcher push (instruction word and its PC)
//   iq_full       registered; queue holds IQ_DEPTH entries
//   dec_flg/ins/pc   queue head to the decoder (flg = head valid)
//   dec_optype/opcode  decoder classification of the head
//   rob/rs/lsb_full_in  target back-pressure
//   jalr_done_in  JALR target resolved
//   rob/rs/lsb_push   dispatch strobes (combinational)

module issue_ctrl #(
  parameter int unsigned IQ_AW = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        fet_vld,
  input  logic [31:0] fet_ins,
  input  logic [31:0] fet_pc,
  output logic        iq_full,
  output logic        dec_flg,
  output logic [31:0] dec_ins,
  output logic [31:0] dec_pc,
  input  logic [3:0]  dec_optype,
  input  logic [3:0]  dec_opcode,
  input  logic        rob_full_in,
  input  logic        rs_full_in,
  input  logic        lsb_full_in,
  input  logic        jalr_done_in,
  output logic        rob_push,
  output logic        rs_push,
  output logic        lsb_push
);

  localparam int unsigned IqDepth = 2 ** IQ_AW;

  // Decoder classification codes shared with the decoder.
  localparam logic [3:0] TypeJum = 4'd2;
  localparam logic [3:0] TypeLad = 4'd4;
  localparam logic [3:0] TypeStr = 4'd5;
  localparam logic [3:0] OpJalr  = 4'd1;

  localparam logic [IQ_AW:0] CntFull = {1'b1, {IQ_AW{1'b0}}};
  localparam logic [IQ_AW-1:0] PtrOne = {{(IQ_AW-1){1'b0}}, 1'b1};
  localparam logic [IQ_AW:0] CntOne = {{IQ_AW{1'b0}}, 1'b1};

  typedef enum logic [0:0] {StRun, StWaitJalr} state_e;

  logic [31:0] ins_mem [IqDepth];
  logic [31:0] pc_mem  [IqDepth];

  logic [IQ_AW-1:0] head_q, head_d;
  logic [IQ_AW-1:0] tail_q, tail_d;
  logic [IQ_AW:0]   count_q, count_d;
  state_e           state_q, state_d;
  logic             iq_full_q, iq_full_d;

  logic tgt_lsb;
  logic is_jalr;
  logic fire;
  logic push_ok;

  assign dec_flg = (count_q != '0);
  assign dec_ins = ins_mem[head_q];
  assign dec_pc  = pc_mem[head_q];
  assign iq_full = iq_full_q;

  assign tgt_lsb = (dec_optype == TypeLad) || (dec_optype == TypeStr);
  assign is_jalr = (dec_optype == TypeJum) && (dec_opcode == OpJalr);

  always_comb begin
    fire = rdy_in & ~clr_in & dec_flg & (state_q == StRun) & ~rob_full_in
         & (tgt_lsb ? ~lsb_full_in : ~rs_full_in);
  end

  // A push into a full queue is dropped even if the head pops in the same cycle.
  assign push_ok = fet_vld & rdy_in & ~clr_in & (count_q < CntFull);

  assign rob_push = fire;
  assign lsb_push = fire & tgt_lsb;
  assign rs_push  = fire & ~tgt_lsb;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (rdy_in) begin
      if (clr_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        state_d = StRun;
      end else begin
        if (fire) head_d = head_q + PtrOne;
        if (push_ok) tail_d = tail_q + PtrOne;
        unique case ({push_ok, fire})
          2'b10:   count_d = count_q + CntOne;
          2'b01:   count_d = count_q - CntOne;
          default: count_d = count_q;
        endcase
        unique case (state_q)
          StRun:      if (fire && is_jalr) state_d = StWaitJalr;
          StWaitJalr: if (jalr_done_in) state_d = StRun;
          default:    state_d = StRun;
        endcase
      end
    end
    iq_full_d = (count_d == CntFull);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= StRun;
      iq_full_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
      iq_full_q <= iq_full_d;
    end
  end

  // Storage has no reset; entries are only observed while counted valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      ins_mem[tail_q] <= fet_ins;
      pc_mem[tail_q]  <= fet_pc;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a queue-based reference model.

module tb_issue_ctrl;

  localparam logic [3:0] TypeAlu = 4'd0;
  localparam logic [3:0] TypeJum = 4'd2;
  localparam logic [3:0] TypeLad = 4'd4;
  localparam logic [3:0] TypeStr = 4'd5;
  localparam logic [3:0] OpJalr  = 4'd1;

  localparam logic [31:0] InsAdd  = 32'h002081b3;
  localparam logic [31:0] InsLw   = 32'h0000a103;
  localparam logic [31:0] InsSw   = 32'h0020a023;
  localparam logic [31:0] InsJalr = 32'h000080e7;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, fet_vld;
  logic [31:0] fet_ins, fet_pc;
  logic        iq_full, dec_flg;
  logic [31:0] dec_ins, dec_pc;
  logic [3:0]  dec_optype, dec_opcode;
  logic        rob_full_in, rs_full_in, lsb_full_in, jalr_done_in;
  logic        rob_push, rs_push, lsb_push;

  issue_ctrl #(.IQ_AW(4)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clr_in      (clr_in),
    .fet_vld     (fet_vld),
    .fet_ins     (fet_ins),
    .fet_pc      (fet_pc),
    .iq_full     (iq_full),
    .dec_flg     (dec_flg),
    .dec_ins     (dec_ins),
    .dec_pc      (dec_pc),
    .dec_optype  (dec_optype),
    .dec_opcode  (dec_opcode),
    .rob_full_in (rob_full_in),
    .rs_full_in  (rs_full_in),
    .lsb_full_in (lsb_full_in),
    .jalr_done_in(jalr_done_in),
    .rob_push    (rob_push),
    .rs_push     (rs_push),
    .lsb_push    (lsb_push)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  // Reference model: the queue contents, whether a JALR is outstanding, and iq_full.
  ent_t q[$];
  bit   wt;
  bit   exp_full;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stand-in for the external decoder: classify by the major opcode field.
  function automatic void decode(input logic [31:0] ins, output logic [3:0] ty,
                                 output logic [3:0] op);
    op = 4'd0;
    case (ins[6:0])
      7'b0000011: ty = TypeLad;
      7'b0100011: ty = TypeStr;
      7'b1100111: begin ty = TypeJum; op = OpJalr; end
      default:    ty = TypeAlu;
    endcase
  endfunction

  task automatic idle_inputs();
    rdy_in = 1'b1; clr_in = 1'b0; fet_vld = 1'b0; fet_ins = '0; fet_pc = '0;
    rob_full_in = 1'b0; rs_full_in = 1'b0; lsb_full_in = 1'b0; jalr_done_in = 1'b0;
  endtask

  // One clock: drive decoder view of the head, check outputs, clock, advance the model.
  task automatic cycle();
    logic [3:0] ty, op;
    bit tgt_lsb, is_jalr, fire, push_ok, has_head;
    has_head = (q.size() != 0);
    if (has_head) decode(q[0].ins, ty, op);
    else begin ty = TypeAlu; op = 4'd0; end
    dec_optype = ty;
    dec_opcode = op;
    #1;
    tgt_lsb = (ty == TypeLad) || (ty == TypeStr);
    is_jalr = (ty == TypeJum) && (op == OpJalr);
    fire = rdy_in && !clr_in && has_head && !wt && !rob_full_in
           && (tgt_lsb ? !lsb_full_in : !rs_full_in);
    check_eq("dec_flg", 32'(dec_flg), 32'(has_head));
    if (has_head) begin
      check_eq("dec_ins", dec_ins, q[0].ins);
      check_eq("dec_pc", dec_pc, q[0].pc);
    end
    check_eq("rob_push", 32'(rob_push), 32'(fire));
    check_eq("rs_push", 32'(rs_push), 32'(fire && !tgt_lsb));
    check_eq("lsb_push", 32'(lsb_push), 32'(fire && tgt_lsb));
    check_eq("iq_full", 32'(iq_full), 32'(exp_full));
    push_ok = fet_vld && (q.size() < 16);
    @(posedge clk_in);
    if (rdy_in) begin
      if (clr_in) begin
        q.delete();
        wt = 1'b0;
      end else begin
        if (fire) begin
          void'(q.pop_front());
          if (is_jalr) wt = 1'b1;
        end else if (wt && jalr_done_in) begin
          wt = 1'b0;
        end
        if (push_ok) q.push_back('{ins: fet_ins, pc: fet_pc});
      end
      exp_full = (q.size() == 16);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    q.delete();
    wt = 1'b0;
    exp_full = 1'b0;
    check_eq("rst_dec_flg", 32'(dec_flg), 32'd0);
    check_eq("rst_iq_full", 32'(iq_full), 32'd0);
    check_eq("rst_strobes", {29'd0, rob_push, rs_push, lsb_push}, 32'd0);
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    fet_vld = 1'b1; fet_ins = ins; fet_pc = pc;
    cycle();
    fet_vld = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    dec_optype = '0;
    dec_opcode = '0;
    @(posedge clk_in);
    #1;
    do_reset();

    // Three ADDs dispatch back to back.
    for (int i = 0; i < 3; i++) push(InsAdd, 32'(4 * i));
    repeat (4) cycle();

    // Fill to 16 under ROB back-pressure, then a dropped 17th push; drain.
    rob_full_in = 1'b1;
    for (int i = 0; i < 16; i++) push(InsAdd, 32'h100 + 32'(4 * i));
    rob_full_in = 1'b0;
    push(InsAdd, 32'h200);
    repeat (17) cycle();

    // Load held by LSB back-pressure, then released.
    lsb_full_in = 1'b1;
    push(InsLw, 32'h300);
    repeat (2) cycle();
    lsb_full_in = 1'b0;
    repeat (2) cycle();

    // JALR holds the following ADD until jalr_done_in.
    push(InsJalr, 32'h400);
    push(InsAdd, 32'h404);
    repeat (5) cycle();
    jalr_done_in = 1'b1;
    cycle();
    jalr_done_in = 1'b0;
    repeat (2) cycle();

    // Flush with a simultaneous fetch on a queue holding 8 entries.
    rob_full_in = 1'b1;
    for (int i = 0; i < 8; i++) push(InsSw, 32'h500 + 32'(4 * i));
    rob_full_in = 1'b0;
    clr_in = 1'b1;
    push(InsAdd, 32'h600);
    clr_in = 1'b0;
    repeat (2) cycle();

    // Global stall with a valid head.
    push(InsAdd, 32'h700);
    rdy_in = 1'b0;
    repeat (3) cycle();
    rdy_in = 1'b1;
    repeat (2) cycle();

    // Randomized traffic with phases of heavy back-pressure.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tbl [4];
      int busy;
      tbl[0] = InsAdd; tbl[1] = InsLw; tbl[2] = InsSw; tbl[3] = InsJalr;
      busy = ((i / 200) % 2 == 1) ? 2 : 8;
      if ($urandom_range(0, 699) == 0) begin
        idle_inputs();
        do_reset();
      end
      rdy_in       = ($urandom_range(0, 7) != 0);
      clr_in       = ($urandom_range(0, 59) == 0);
      fet_vld      = ($urandom_range(0, 2) != 0);
      fet_ins      = tbl[$urandom_range(0, 3)];
      fet_pc       = $urandom;
      rob_full_in  = ($urandom_range(0, busy) == 0);
      rs_full_in   = ($urandom_range(0, busy) == 0);
      lsb_full_in  = ($urandom_range(0, busy) == 0);
      jalr_done_in = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
